// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and helpers for the register-file write-back path.
package regfile_ctrl_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // Width of an index able to address n items (n >= 2).
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after rr_ptr.
module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o
);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   idx_s;
    logic               found_s;

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int  cand;
        logic hit;
        grant_s = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            cand = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
            hit  = en_i && req_i[cand] && !found_s;
            grant_s[cand] = hit;
            idx_s   = hit ? PTR_W'(cand) : idx_s;
            found_s = found_s | hit;
        end
    end

    // Next pointer: one past the winner on a transfer, otherwise hold.
    always_comb begin
        if (adv_i) begin
            if (idx_s == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_s + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o     = grant_s;
    assign grant_idx_o = idx_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: arbitrates requesters onto the register-file write
// port through one output register and tracks pending writes in a scoreboard.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = regfile_ctrl_pkg::DATA_W,
    parameter int ADDR_W  = regfile_ctrl_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        stall,
    input  logic                        issue_valid,
    input  logic [ADDR_W-1:0]           issue_reg,
    output logic                        write_enable,
    output logic [ADDR_W-1:0]           write_reg,
    output logic [DATA_W-1:0]           write_data,
    output logic [(1 << ADDR_W)-1:0]    busy
);

    localparam int NREGS = 1 << ADDR_W;
    localparam int PTR_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   idx_s;
    logic               xfer_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [DATA_W-1:0]  data_s;

    logic               we_q;
    logic               we_d;
    logic [ADDR_W-1:0]  wreg_q;
    logic [ADDR_W-1:0]  wreg_d;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  wdata_d;
    logic [NREGS-1:0]   busy_q;
    logic [NREGS-1:0]   busy_d;
    logic [NREGS-1:0]   set_s;
    logic [NREGS-1:0]   clr_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst),
        .req_i       (req_valid),
        .en_i        (!stall),
        .adv_i       (xfer_s),
        .grant_o     (grant_s),
        .grant_idx_o (idx_s)
    );

    // A grant always coincides with a valid request, so any grant is a transfer.
    assign xfer_s    = |grant_s;
    assign req_ready = grant_s;

    // Operand mux selected by the granted index.
    always_comb begin
        logic sel;
        addr_s = '0;
        data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel    = xfer_s && (idx_s == PTR_W'(i));
            addr_s = addr_s | ({ADDR_W{sel}} & req_addr[i*ADDR_W +: ADDR_W]);
            data_s = data_s | ({DATA_W{sel}} & req_data[i*DATA_W +: DATA_W]);
        end
    end

    // Output-stage next state: address/data hold when nothing transfers.
    always_comb begin
        we_d = xfer_s;
        if (xfer_s) begin
            wreg_d  = addr_s;
            wdata_d = data_s;
        end else begin
            wreg_d  = wreg_q;
            wdata_d = wdata_q;
        end
    end

    // Scoreboard next state; the set mask is applied last so it wins a collision.
    always_comb begin
        set_s  = issue_valid ? ({{(NREGS-1){1'b0}}, 1'b1} << issue_reg) : '0;
        clr_s  = we_q        ? ({{(NREGS-1){1'b0}}, 1'b1} << wreg_q)    : '0;
        busy_d = (busy_q & ~clr_s) | set_s;
    end

    // Output stage and scoreboard registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign write_enable = we_q;
    assign write_reg    = wreg_q;
    assign write_data   = wdata_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (3 requesters, 32 regs).
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        stall;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] busy;

    logic [4:0]  addr [3];
    logic [31:0] data [3];

    int n_checks = 0;
    int n_fail   = 0;

    assign req_addr = {addr[2], addr[1], addr[0]};
    assign req_data = {data[2], data[1], data[0]};

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .stall        (stall),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid   = 3'b000;
        stall       = 1'b0;
        issue_valid = 1'b0;
        rst         = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        req_valid   = 3'b111;
        stall       = 1'b0;
        issue_valid = 1'b1;
        issue_reg   = 5'd5;
        addr[0] = 5'd10; addr[1] = 5'd11; addr[2] = 5'd12;
        data[0] = 32'h1111_0000; data[1] = 32'h2222_0000; data[2] = 32'h3333_0000;
        repeat (3) step();
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", write_enable); end
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_checks++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_wreg: got %0d want 0", write_reg); end
        n_checks++; if (write_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", write_data); end
        issue_valid = 1'b0;
        rst = 1'b1;
        #2;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 001", req_ready); end
        step();
        req_valid = 3'b000;
        n_checks++; if (write_enable !== 1'b1 || write_reg !== 5'd10) begin n_fail++; $display("FAIL reset_first_write: got we=%b reg=%0d want we=1 reg=10", write_enable, write_reg); end
        step();
    endtask

    task automatic test_single_write();
        step();
        issue_valid = 1'b1;
        issue_reg   = 5'd7;
        step();
        issue_valid = 1'b0;
        n_checks++; if (busy[7] !== 1'b1) begin n_fail++; $display("FAIL single_busy_set: got %b want 1", busy[7]); end
        addr[0] = 5'd7;
        data[0] = 32'hDEAD_BEEF;
        req_valid = 3'b001;
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready: got %b want 001", req_ready); end
        step();
        req_valid = 3'b000;
        n_checks++; if (write_enable !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", write_enable); end
        n_checks++; if (write_reg !== 5'd7) begin n_fail++; $display("FAIL single_wreg: got %0d want 7", write_reg); end
        n_checks++; if (write_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_wdata: got %h want deadbeef", write_data); end
        n_checks++; if (busy[7] !== 1'b1) begin n_fail++; $display("FAIL single_busy_pending: got %b want 1", busy[7]); end
        step();
        n_checks++; if (busy[7] !== 1'b0) begin n_fail++; $display("FAIL single_busy_clear: got %b want 0", busy[7]); end
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %b want 0", write_enable); end
        n_checks++; if (write_reg !== 5'd7 || write_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_hold: got reg=%0d data=%h want 7/deadbeef", write_reg, write_data); end
    endtask

    task automatic test_round_robin();
        logic [4:0]  exp_reg [6];
        logic [2:0]  exp_rdy [6];
        exp_reg = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
        exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        apply_reset();
        addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3;
        data[0] = 32'h0000_0101; data[1] = 32'h0000_0202; data[2] = 32'h0000_0303;
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++; if (req_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy[k]); end
            step();
            n_checks++; if (write_enable !== 1'b1 || write_reg !== exp_reg[k]) begin n_fail++; $display("FAIL rr_write[%0d]: got we=%b reg=%0d want we=1 reg=%0d", k, write_enable, write_reg, exp_reg[k]); end
            n_checks++; if (write_data !== {24'h0, 3'b0, exp_reg[k], 3'b0, exp_reg[k]}) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want reg-coded data", k, write_data); end
        end
        req_valid = 3'b000;
        step();
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", write_enable); end
    endtask

    task automatic test_stall_withdraw();
        apply_reset();
        addr[0] = 5'd4;  data[0] = 32'h0000_0004;
        addr[1] = 5'd12; data[1] = 32'h0000_000C;
        addr[2] = 5'd20; data[2] = 32'h0000_0014;
        req_valid = 3'b001;
        step();
        stall     = 1'b1;
        req_valid = 3'b010;
        #1;
        n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL stall_ready_c1: got %b want 000", req_ready); end
        n_checks++; if (write_enable !== 1'b1 || write_reg !== 5'd4) begin n_fail++; $display("FAIL stall_inflight: got we=%b reg=%0d want 1/4", write_enable, write_reg); end
        for (int c = 2; c <= 4; c++) begin
            step();
            n_checks++; if (req_ready !== 3'b000 || write_enable !== 1'b0) begin n_fail++; $display("FAIL stall_c%0d: got ready=%b we=%b want 000/0", c, req_ready, write_enable); end
        end
        step();
        stall = 1'b0;
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL stall_release_ready: got %b want 010", req_ready); end
        step();
        req_valid = 3'b000;
        n_checks++; if (write_enable !== 1'b1 || write_reg !== 5'd12 || write_data !== 32'h0000_000C) begin n_fail++; $display("FAIL stall_release_write: got we=%b reg=%0d data=%h want 1/12/c", write_enable, write_reg, write_data); end
        stall     = 1'b1;
        req_valid = 3'b100;
        step();
        req_valid = 3'b000;
        stall     = 1'b0;
        step();
        step();
        n_checks++; if (write_enable !== 1'b0 || write_reg !== 5'd12) begin n_fail++; $display("FAIL withdraw_no_write: got we=%b reg=%0d want 0/12", write_enable, write_reg); end
    endtask

    task automatic test_collision();
        apply_reset();
        issue_valid = 1'b1;
        issue_reg   = 5'd9;
        step();
        issue_valid = 1'b0;
        addr[0] = 5'd9;
        data[0] = 32'hCAFE_F00D;
        req_valid = 3'b001;
        step();
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        issue_reg   = 5'd9;
        n_checks++; if (write_enable !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL coll_write: got we=%b reg=%0d data=%h want 1/9/cafef00d", write_enable, write_reg, write_data); end
        step();
        issue_valid = 1'b0;
        n_checks++; if (busy[9] !== 1'b1) begin n_fail++; $display("FAIL coll_busy: got %b want 1", busy[9]); end
        step();
        n_checks++; if (busy !== 32'h0000_0200) begin n_fail++; $display("FAIL coll_busy_hold: got %h want 00000200", busy); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3;
        data[0] = 32'hA1; data[1] = 32'hA2; data[2] = 32'hA3;
        issue_valid = 1'b1;
        issue_reg   = 5'd30;
        req_valid   = 3'b111;
        step();
        issue_valid = 1'b0;
        step();
        n_checks++; if (write_enable !== 1'b1 || write_reg !== 5'd2) begin n_fail++; $display("FAIL async_pre: got we=%b reg=%0d want 1/2", write_enable, write_reg); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (write_enable !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'h0) begin n_fail++; $display("FAIL async_clear: got we=%b reg=%0d data=%h want 0/0/0", write_enable, write_reg, write_data); end
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL async_busy: got %h want 0", busy); end
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL async_ptr: got %b want 001", req_ready); end
        #2;
        rst = 1'b1;
        step();
        n_checks++; if (write_enable !== 1'b1 || write_reg !== 5'd1) begin n_fail++; $display("FAIL async_restart: got we=%b reg=%0d want 1/1", write_enable, write_reg); end
        req_valid = 3'b000;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b0;
        req_valid   = 3'b000;
        stall       = 1'b0;
        issue_valid = 1'b0;
        issue_reg   = 5'd0;
        addr[0] = 5'd0; addr[1] = 5'd0; addr[2] = 5'd0;
        data[0] = 32'h0; data[1] = 32'h0; data[2] = 32'h0;
        #1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_stall_withdraw();
        test_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
